matmul_mem_arbiter: RTL
=======================

Name: matmul_mem_arbiter

Overview:
- Shares the single-port operand/result memory of the 3x3 matrix-multiply datapath between three requesters: operand loader (port 0), result writeback (port 1) and host/debug access (port 2).
- Round-robin arbitration, with an optional burst lock so that a requester can stream a whole 9-word matrix without interleaving.
- Tags each read so that data returns only to the requester that issued it.

Parameters:
- AW, 5, memory address width (32 words, enough for A, B and the result matrix).
- DW, 8, data word width.
- RD_LAT, 1, memory read latency in cycles (1..4).
- LOCK_MAX, 16, maximum consecutive cycles one requester may hold a lock before forced release.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  3  per-requester access request, bit i = port i.
- we  in  3  per-requester write enable; 0 means read.
- lock  in  3  per-requester burst-lock request.
- addr  in  3*AW  packed addresses, port i at [i*AW +: AW].
- wdata  in  3*DW  packed write data, port i at [i*DW +: DW].
- gnt  out  3  one-hot grant; the access of port i happens in a cycle where gnt[i]=1.
- rvalid  out  3  read data valid for port i.
- rdata  out  DW  read data, shared; qualified by rvalid.
- lock_timeout  out  1  sticky flag, set when a lock is force-released.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ARB, rr_ptr=0, lock_cnt=0, read tag pipeline cleared, lock_timeout=0.
  - gnt, rvalid, mem_en and mem_we are forced 0 while rst=0.
  - rdata, mem_addr and mem_wdata read 0 while rst=0.
- Grant timing:
  - gnt is combinational from req, state and rr_ptr; at most one bit is set.
  - Memory signals are muxed from the granted port in the same cycle: mem_en=|gnt, mem_we=we[g], mem_addr=addr[g], mem_wdata=wdata[g].
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - Each cycle with gnt[i]=1 completes exactly one access.
- Read return:
  - A read granted in cycle t gives rvalid[i]=1 and rdata=mem_rdata in cycle t+RD_LAT.
  - Implemented as an RD_LAT-deep shift register of {valid, 2-bit id}.
  - Back-to-back reads from different ports return in issue order with no bubbles.
  - Writes produce no rvalid.
- State ARB:
  - Grant the first requesting port searching from rr_ptr upward, modulo 3.
  - On a grant to port g: rr_ptr <= (g+1) mod 3.
  - If lock[g]=1 at grant: go to LOCKED(g), lock_cnt <= 1.
  - No requests: no grant, pointer unchanged.
- State LOCKED(o):
  - Only port o may be granted; gnt[o]=req[o]. Other requests wait.
  - lock_cnt increments every cycle and saturates at LOCK_MAX.
  - Owner stays locked while its req is low and lock is high (idle hold; no other port is granted).
  - lock[o]=0: the access in that cycle (if req[o]) is still granted; go to ARB next cycle.
  - lock_cnt==LOCK_MAX: this cycle's access is granted, then go to ARB with lock_timeout <= 1 (sticky until reset).
  - After a forced release, rr_ptr already points past o, so o cannot relock before the others are served.
- Simultaneous events:
  - All three requesting with rr_ptr=0 grants port 0, then 1, then 2.
  - lock asserted together with req on a newly granted port takes effect from the grant cycle.
  - Reset mid-burst drops any outstanding read returns; no rvalid is emitted for them.
- Width rules:
  - rr_ptr and the tag id are 2 bits; values 3 are unreachable.
  - lock_cnt is clog2(LOCK_MAX+1) bits.

Decomposition:
- Shared package matmul_pkg:
  - state localparams ARB=1'b0, LOCKED=1'b1.
  - port id constants PORT_LOAD=0, PORT_WB=1, PORT_HOST=2.
  - default AW/DW constants shared with the datapath and control unit.
- One sub-module, rd_tag_pipe:
  - parameterised RD_LAT-deep {valid,id} shift register with asynchronous active-low clear.
  - decodes to the rvalid one-hot.

Test Plan:
- Reset release, then req=3'b111 all reads, addr 0/9/18, RD_LAT=1 -> gnt 001,010,100 on cycles 1-3; rvalid 001,010,100 on cycles 2-4 with rdata=mem[0],mem[9],mem[18].
- Port 0 lock=1, req held 9 cycles (addr 0..8), port 1 requesting throughout -> gnt=001 for 9 cycles; gnt=010 on cycle 10 after lock drops with the last access.
- Port 2 lock held 20 cycles, LOCK_MAX=16, ports 0/1 requesting -> port 2 granted 16 cycles, then lock_timeout=1 and gnt=001 next, then 010.
- Locked port 1 drops req but keeps lock for 3 cycles, port 0 requesting -> gnt=000 for those 3 cycles; no grant to port 0 until lock falls.
- RD_LAT=3, reads from ports 0,1,2 back-to-back, rst pulsed low after cycle 2 -> all outputs 0 immediately; no rvalid appears after reset release.
- Port 1 write addr=20 wdata=8'h5A, then port 2 read addr=20 -> mem_we=1 with mem_addr=20 on the grant cycle; port 2 receives rdata=8'h5A with rvalid=100.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply memory subsystem.
package matmul_pkg;

    localparam int unsigned DEF_AW = 5;
    localparam int unsigned DEF_DW = 8;
    localparam int unsigned NPORT  = 3;
    localparam int unsigned ID_W   = 2;

    localparam logic [ID_W-1:0] PORT_LOAD = 2'd0;
    localparam logic [ID_W-1:0] PORT_WB   = 2'd1;
    localparam logic [ID_W-1:0] PORT_HOST = 2'd2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    // (p + k) mod NPORT for p, k in 0..NPORT-1
    function automatic logic [ID_W-1:0] port_add(input logic [ID_W-1:0] p,
                                                 input logic [ID_W-1:0] k);
        logic [ID_W:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s > {1'b0, PORT_HOST}) ? ID_W'(s - 3'(NPORT)) : s[ID_W-1:0];
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline: delays {valid,id} by RD_LAT cycles and decodes it
// into the per-port rvalid one-hot.
module rd_tag_pipe
    import matmul_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  rd_tag_t          i_tag,
    output logic [NPORT-1:0] o_rvalid
);

    rd_tag_t r_pipe [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < int'(RD_LAT); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rvalid = r_pipe[RD_LAT-1].valid ? (NPORT'(1) << r_pipe[RD_LAT-1].id) : '0;

endmodule

// File: rtl/matmul_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port operand/result
// memory between loader, writeback and host ports; reads are tagged back.
module matmul_mem_arbiter
    import matmul_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT-1:0]    lock,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] wdata,
    output logic [NPORT-1:0]    gnt,
    output logic [NPORT-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                lock_timeout,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr, w_rr_nxt;
    logic [ID_W-1:0]  r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic             r_lock_timeout;
    logic             w_timeout_set;
    logic [NPORT-1:0] w_gnt;
    logic [ID_W-1:0]  w_gid;
    logic [ID_W-1:0]  w_cand;
    logic             w_found;
    rd_tag_t          w_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ARB;
            r_rr_ptr       <= PORT_LOAD;
            r_owner        <= PORT_LOAD;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr_ptr       <= w_rr_nxt;
            r_owner        <= w_owner_nxt;
            r_lock_cnt     <= w_lock_cnt_nxt;
            r_lock_timeout <= r_lock_timeout | w_timeout_set;
        end
    end

    // Grant selection and next-state
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_timeout_set  = 1'b0;
        w_gnt          = '0;
        w_gid          = r_rr_ptr;
        w_cand         = r_rr_ptr;
        w_found        = 1'b0;
        case (r_state)
            ARB: begin
                w_lock_cnt_nxt = '0;
                for (int k = 0; k < int'(NPORT); k++) begin
                    w_cand = port_add(r_rr_ptr, ID_W'(k));
                    if (!w_found && req[w_cand]) begin
                        w_found = 1'b1;
                        w_gid   = w_cand;
                    end
                end
                if (w_found) begin
                    w_gnt[w_gid] = 1'b1;
                    w_rr_nxt     = port_add(w_gid, ID_W'(1));
                    if (lock[w_gid]) begin
                        w_state_nxt    = LOCKED;
                        w_owner_nxt    = w_gid;
                        w_lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                w_gid          = r_owner;
                w_gnt[r_owner] = req[r_owner];
                w_lock_cnt_nxt = (r_lock_cnt == CNT_W'(LOCK_MAX)) ? r_lock_cnt
                                                                  : r_lock_cnt + CNT_W'(1);
                // the cycle that brings the hold count to LOCK_MAX is the last one
                if (w_lock_cnt_nxt == CNT_W'(LOCK_MAX)) begin
                    w_state_nxt   = ARB;
                    w_timeout_set = 1'b1;
                end else if (!lock[r_owner]) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    assign gnt          = rst ? w_gnt : '0;
    assign mem_en       = |gnt;
    assign mem_we       = mem_en & we[w_gid];
    assign mem_addr     = mem_en ? addr[AW*32'(w_gid) +: AW] : '0;
    assign mem_wdata    = mem_en ? wdata[DW*32'(w_gid) +: DW] : '0;
    assign lock_timeout = r_lock_timeout;

    assign w_tag.valid = mem_en & ~mem_we;
    assign w_tag.id    = w_gid;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .rst_n    (rst),
        .i_tag    (w_tag),
        .o_rvalid (rvalid)
    );

    assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule
